sha256: RTL and testbench

SHA256 -- requirements
Module: sha256

---
 rtl/sha256.sv | 114 +++++++++++
 tb/tb_sha256.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256.sv
// rtl/sha256.sv - SHA-256 single-block compression, one round per clock
// Optional macro SHA256_RESTART_EN: enable while busy aborts and restarts on the new inputs.
module sha256 (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         enable,
    input  logic [511:0] data,
    input  logic [255:0] current_hash,
    output logic [255:0] hash,
    output logic         hash_done
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b0, x[31:3]};
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    state_t      state;
    logic [5:0]  round;
    logic        primed;
    logic [31:0] w [16];
    logic [31:0] hin [8];
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] k_t, t1, t2, w_next;
    logic        start;

`ifdef SHA256_RESTART_EN
    assign start = enable;
`else
    assign start = enable && (state == IDLE);
`endif

    // w[0] is W[t]; w_next is W[t+16], computed from the current window.
    assign k_t    = K[round];
    assign t1     = h + bsig1(e) + ((e & f) ^ (~e & g)) + k_t + w[0];
    assign t2     = bsig0(a) + ((a & b) ^ (a & c) ^ (b & c));
    assign w_next = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            round     <= 6'd0;
            primed    <= 1'b0;
            hash      <= 256'd0;
            hash_done <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= 32'd0;
            for (int i = 0; i < 8; i++) hin[i] <= 32'd0;
            {a, b, c, d, e, f, g, h} <= 256'd0;
        end else begin
            hash_done <= 1'b0;
            if (start) begin
                for (int i = 0; i < 16; i++) w[i] <= data[511 - 32*i -: 32];
                for (int i = 0; i < 8; i++) hin[i] <= current_hash[255 - 32*i -: 32];
                round  <= 6'd0;
                primed <= 1'b0;
                state  <= ROUND;
            end else begin
                case (state)
                    ROUND: begin
                        if (!primed) begin
                            // Extra cycle loading the working variables from the captured chaining value.
                            {a, b, c, d, e, f, g, h} <= {hin[0], hin[1], hin[2], hin[3],
                                                         hin[4], hin[5], hin[6], hin[7]};
                            primed <= 1'b1;
                        end else begin
                            h <= g;
                            g <= f;
                            f <= e;
                            e <= d + t1;
                            d <= c;
                            c <= b;
                            b <= a;
                            a <= t1 + t2;
                            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
                            w[15] <= w_next;
                            round <= round + 6'd1;
                            if (round == 6'd63) state <= FINAL;
                        end
                    end
                    FINAL: begin
                        hash <= {hin[0] + a, hin[1] + b, hin[2] + c, hin[3] + d,
                                 hin[4] + e, hin[5] + f, hin[6] + g, hin[7] + h};
                        hash_done <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sha256.sv
// tb/tb_sha256.sv - scoreboard bench for sha256 against a behavioural SHA-256 model
module tb_sha256;
    logic         clk = 1'b0;
    logic         n_rst = 1'b1;
    logic         enable = 1'b0;
    logic [511:0] data = '0;
    logic [255:0] current_hash = '0;
    logic [255:0] hash;
    logic         hash_done;

    sha256 dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .data(data),
        .current_hash(current_hash), .hash(hash), .hash_done(hash_done)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct {
        logic [255:0] h;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [255:0] last_hash = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] model(input logic [255:0] hv, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  v [8];
        logic [31:0]  t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        for (int i = 0; i < 8; i++) v[i] = hv[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255 - 32*i -: 32] = hv[255 - 32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every completion and checks digest, latency and output stability.
    always @(negedge clk) begin
        if (!n_rst) begin
            last_hash = '0;
        end else if (hash_done) begin
            if (q.size() == 0) begin
                check("spurious_done", 256'd1, 256'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("digest", hash, e.h);
                check("done_cycle", 256'(cyc), 256'(e.cyc));
            end
            last_hash = hash;
        end else begin
            check("hash_stable", hash, last_hash);
        end
    end

    task automatic drive(input logic [255:0] hv, input logic [511:0] blk, output int start);
        current_hash = hv;
        data         = blk;
        enable       = 1'b1;
        @(posedge clk);
        #1;
        enable = 1'b0;
        start  = cyc;
    endtask

    task automatic run(input logic [255:0] hv, input logic [511:0] blk, input logic [255:0] exp_h);
        int s;
        drive(hv, blk, s);
        q.push_back('{h: exp_h, cyc: s + 66});
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() > 0; i++) @(posedge clk);
        check("drain_timeout", 256'(q.size()), 256'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [511:0] blk_empty, blk_abc, blk_ABC, blk_a64, blk_pad, b2;
        logic [255:0] h1, hr, hr2;
        int s1, s2;

        blk_empty = {8'h80, 504'd0};
        blk_abc   = {24'h616263, 8'h80, 416'd0, 64'd24};
        blk_ABC   = {24'h414243, 8'h80, 416'd0, 64'd24};
        blk_a64   = {64{8'h41}};
        blk_pad   = {8'h80, 440'd0, 64'd512};

        #3 n_rst = 1'b0;
        #1;
        check("reset_hash", hash, 256'd0);
        check("reset_done", 256'(hash_done), 256'd0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;

        run(IV, blk_empty, 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
        drain();
        run(IV, blk_abc, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        drain();
        run(IV, blk_ABC, 256'hb5d4045c3f466fa91fe2cc6abe79232a1a57cdf104f7a26e716e0a1e2789df78);
        drain();

        // Two-block chain; inputs are disturbed after the start edge.
        h1 = model(IV, blk_a64);
        run(IV, blk_a64, h1);
        drain();
        run(h1, blk_pad, model(h1, blk_pad));
        repeat (2) @(posedge clk);
        #1;
        current_hash = IV;
        data         = rnd512();
        drain();

        // Back-to-back runs, each enable held in the cycle hash_done is high.
        for (int n = 0; n < 4; n++) begin
            hr = rnd256();
            b2 = rnd512();
            run(hr, b2, model(hr, b2));
            repeat (66) @(posedge clk);
            #1;
        end
        drain();

        // Reset at round 30 abandons the run.
        run(IV, blk_abc, 256'd0);
        repeat (31) @(posedge clk);
        #1 n_rst = 1'b0;
        #1;
        check("midrun_reset_hash", hash, 256'd0);
        check("midrun_reset_done", 256'(hash_done), 256'd0);
        q.delete();
        @(negedge clk);
        @(posedge clk);
        #1 n_rst = 1'b1;
        @(posedge clk);
        #1;
        run(IV, blk_abc, 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);
        drain();

        // Second enable at round 10.
        hr = rnd256();
        b2 = rnd512();
        drive(hr, b2, s1);
        q.push_back('{h: model(hr, b2), cyc: s1 + 66});
        repeat (11) @(posedge clk);
        #1;
        hr2 = rnd256();
        b2  = rnd512();
        drive(hr2, b2, s2);
`ifdef SHA256_RESTART_EN
        void'(q.pop_back());
        q.push_back('{h: model(hr2, b2), cyc: s2 + 66});
`endif
        drain();

        // Random single runs.
        for (int n = 0; n < 5; n++) begin
            hr = rnd256();
            b2 = rnd512();
            run(hr, b2, model(hr, b2));
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
